// File: rtl/tc_ser_pkg.sv
// tc_ser_pkg: shared state encoding and lane geometry for the byte serializer
package tc_ser_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/tc_byte_serializer64_if.sv
// tc_byte_serializer64_if: word-in / byte-out handshake bundle
interface tc_byte_serializer64_if;
  import tc_ser_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [LANES*BYTE_W-1:0] in_data;
  logic [IDX_W-1:0] in_last_idx;
  logic out_valid;
  logic out_ready;
  logic [BYTE_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic out_last;
  logic busy;
  modport master (output in_valid, in_data, in_last_idx, out_ready,
                  input in_ready, out_valid, out_data, out_idx, out_last, busy);
  modport slave (input in_valid, in_data, in_last_idx, out_ready,
                 output in_ready, out_valid, out_data, out_idx, out_last, busy);
endinterface

// File: rtl/TC_Splitter64.sv
// TC_Splitter64: breaks a 64-bit word into its eight byte lanes
module TC_Splitter64 (
  input  logic [63:0] din,
  output logic [7:0]  out0,
  output logic [7:0]  out1,
  output logic [7:0]  out2,
  output logic [7:0]  out3,
  output logic [7:0]  out4,
  output logic [7:0]  out5,
  output logic [7:0]  out6,
  output logic [7:0]  out7
);
  assign {out7, out6, out5, out4, out3, out2, out1, out0} = din;
endmodule

// File: rtl/tc_byte_serializer64.sv
// tc_byte_serializer64: holds one 64-bit word and streams 1-8 of its bytes out
module tc_byte_serializer64 import tc_ser_pkg::*; #(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter bit    MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst,
  tc_byte_serializer64_if.slave bus
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, last_q, last_d, lane_idx;
  logic [LANES*BYTE_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] lane [LANES];
  logic send, fire, last_b, accept;
  logic unused_params;
  assign unused_params = (UUID != 0) || (NAME != "");
  TC_Splitter64 u_split (
    .din (word_q),
    .out0(lane[0]), .out1(lane[1]), .out2(lane[2]), .out3(lane[3]),
    .out4(lane[4]), .out5(lane[5]), .out6(lane[6]), .out7(lane[7])
  );
  assign send     = (state_q == SEND);
  assign lane_idx = MSB_FIRST ? last_q - cnt_q : cnt_q;
  assign last_b   = send & (cnt_q == last_q);
  assign fire     = send & bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready;
  assign bus.in_ready  = !send | (fire & last_b);
  assign bus.out_valid = send;
  assign bus.busy      = send;
  assign bus.out_last  = last_b;
  assign bus.out_idx   = send ? lane_idx : '0;
  assign bus.out_data  = send ? lane[lane_idx] : '0;
  // next state: a new word may load on the same edge the previous last byte leaves
  always_comb begin
    state_d = accept ? SEND : (fire & last_b) ? IDLE : state_q;
    cnt_d   = accept ? '0 : (fire & !last_b) ? cnt_q + 3'd1 : cnt_q;
    word_d  = accept ? bus.in_data : word_q;
    last_d  = accept ? bus.in_last_idx : last_q;
  end
  // state registers; reset drops any partially sent word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end
endmodule
